supply_threshold_monitor: RTL and testbench
===========================================

Name: supply_threshold_monitor

Overview:
Synthesizable, multi-channel successor of the behavioural supply ramp/threshold checker. It classifies per-channel ADC supply samples into NOMINAL/WARN/ERROR/BREAKDOWN levels, with programmable thresholds, hysteresis and debounce. Breakdown is latched. Every committed level change is pushed into a small event FIFO drained over a valid/ready handshake. Sits between the supply-sense ADC sequencer and the safety/interrupt controller.

Parameters:
NCH, 4, number of monitored supply channels (1..16)
W, 8, sample/threshold code width
DEBOUNCE, 3, consecutive same-class samples needed to commit WARN/ERROR or a downward change (>=1)
DCNT_W, 4, debounce counter width; must satisfy 2**DCNT_W > DEBOUNCE
EVT_DEPTH, 4, event FIFO depth (power of two)

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
smp_valid  in  1  sample strobe
smp_ch  in  $clog2(NCH)  sample channel index; index >= NCH ignored
smp_code  in  W  unsigned sample code
cfg_vref  in  W  nominal threshold (WARN when code >= vref)
cfg_vmax  in  W  maximal threshold (ERROR when code >= vmax)
cfg_vbrk  in  W  breakdown threshold (BREAKDOWN when code > vbrk, strict)
cfg_hyst  in  W  downward hysteresis
clr_brk  in  NCH  per-channel breakdown clear, one-cycle pulse
level  out  2*NCH  committed level per channel: 0 NOM, 1 WARN, 2 ERR, 3 BRK
warn_any  out  1  OR of channels at WARN
err_any  out  1  OR of channels at ERR
brk_any  out  1  OR of channels at BRK
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_ch  out  $clog2(NCH)  event channel
evt_from  out  2  level before the change
evt_to  out  2  level after the change
evt_ovf  out  1  sticky: event dropped because FIFO full; cleared only by reset

Behaviour:
- Reset (rst_n=0 at clk edge): all levels NOM, debounce counters 0, candidates NOM, FIFO empty, evt_valid=0, evt_ovf=0, *_any=0.
- Raw classification of the sample: BRK if code>vbrk; else ERR if code>=vmax; else WARN if code>=vref; else NOM. Config is assumed ordered vref<=vmax<=vbrk; unordered config is not checked.
- Downward hysteresis: a class below the current level is only taken when code < (threshold of current level) - hyst. The subtraction saturates at 0 (code can never be < 0). Otherwise the class is held at the current level.
- Per-channel FSM, states NOM/WARN/ERR/BRK. Only the addressed channel updates, on the cycle smp_valid=1.
  - Class BRK: commit to BRK in the same cycle. Latency is one clk: level is visible the cycle after the sample. Debounce is bypassed.
  - Class equals current level: counter cleared.
  - Class differs from current level and equals the candidate: counter++. Commit when counter+1 == DEBOUNCE, then clear the counter.
  - Class differs from both: candidate <= class, counter <= 1. Commit immediately if DEBOUNCE==1.
  - BRK is sticky. In BRK, samples are ignored. clr_brk[ch] forces NOM and clears the counter; it pushes event BRK->NOM. If clr_brk and a BRK-class sample hit the same channel in the same cycle, the sample wins and the channel stays BRK with no event.
- Every commit pushes {ch, from, to} into the FIFO. Multiple same-cycle pushes are not possible from samples (one channel per cycle). When clr_brk hits several channels in one cycle, the lowest index is pushed first; any push beyond free space is dropped and sets evt_ovf.
- FIFO: first-word-fall-through, showahead. evt_* are valid while evt_valid=1; pop on evt_valid&&evt_ready. A push and a pop in the same cycle when full are both accepted, with no overflow.
- *_any outputs are registered from the committed levels (one cycle after level).

Decomposition:
- Package supply_mon_pkg: enum lvl_t {LVL_NOM, LVL_WARN, LVL_ERR, LVL_BRK} (2 bits); struct evt_t {ch, from, to}; function classify().
- Sub-module sync_fifo (parametric WIDTH, DEPTH, FWFT, with full/empty), reused for the event queue.
- Channel FSMs are generated inline.

Test Plan:
- NCH=4, W=8, vref=50, vmax=70, vbrk=90, hyst=5, DEBOUNCE=3. Ramp ch0 by +10 from 0 (0,10..90): level0 reaches WARN only after samples 50,60,70? No: 50,60 give WARN candidate count 2, then 70 re-candidates ERR. Check no commit until three consecutive same class. Feed 55,55,55 -> WARN committed after 3rd sample, event {0,NOM,WARN}.
- ch1 single sample 91 -> level1=BRK next cycle, brk_any next+1, event {1,NOM,BRK}. Then 0,0,0 -> stays BRK. clr_brk[1] -> NOM, event {1,BRK,NOM}.
- Hysteresis: ch2 at WARN (vref=50). Samples 47,47,47 -> stays WARN. Samples 44,44,44 -> NOM after 3rd.
- Interleaved: ch0=75, ch3=75, ch0=75, ch3=75, ch0=75 -> ch0 commits ERR, ch3 still candidate only.
- evt_ready=0, drive 5 commits -> 4 stored, evt_ovf=1. Drain -> the 4 oldest events in order. Reset mid-stream -> all outputs zero.
- DEBOUNCE=1 build: sample 55 -> WARN committed next cycle.

Source files
------------

// File: rtl/supply_mon_pkg.sv
// Shared types for the supply threshold monitor: severity levels, the event
// record pushed on every committed level change, and raw sample classification.
package supply_mon_pkg;

    localparam int CH_MAX_W = 4;

    typedef enum logic [1:0] {
        LVL_NOM  = 2'd0,
        LVL_WARN = 2'd1,
        LVL_ERR  = 2'd2,
        LVL_BRK  = 2'd3
    } lvl_t;

    typedef struct packed {
        logic [CH_MAX_W-1:0] ch;
        lvl_t                from;
        lvl_t                to;
    } evt_t;

    // Takes pre-computed comparator results so the function stays width-agnostic.
    function automatic lvl_t classify(input logic above_brk, input logic at_max, input logic at_ref);
        if (above_brk)   return LVL_BRK;
        else if (at_max) return LVL_ERR;
        else if (at_ref) return LVL_WARN;
        else             return LVL_NOM;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with NWR ordered write ports (lowest port first) and one
// read port; writes beyond the free space are dropped and flagged on drop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NWR   = 1,
    parameter bit FWFT  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 full,
    output logic                 empty,
    output logic                 drop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             pop;
    logic [NWR-1:0]   slot_en;
    logic [AW-1:0]    slot_idx [NWR];
    int               space;
    int               n_acc;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign pop   = rd_en && !empty;

    // A pop in the same cycle frees one slot for the incoming writes.
    always_comb begin
        space = DEPTH - int'(count_reg) + (pop ? 1 : 0);
        n_acc = 0;
        drop  = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            slot_en[k]  = 1'b0;
            slot_idx[k] = '0;
            if (wr_en[k]) begin
                if (n_acc < space) begin
                    slot_en[k]  = 1'b1;
                    slot_idx[k] = AW'(int'(wr_ptr_reg) + n_acc);
                    n_acc       = n_acc + 1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= AW'(int'(wr_ptr_reg) + n_acc);
            rd_ptr_reg <= rd_ptr_reg + AW'(pop);
            count_reg  <= (AW+1)'(int'(count_reg) + n_acc - (pop ? 1 : 0));
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NWR; k++) begin
            if (slot_en[k]) mem[slot_idx[k]] <= wr_data[k*WIDTH +: WIDTH];
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data = mem[rd_ptr_reg];
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_reg;
            always_ff @(posedge clk) begin
                if (pop) rd_data_reg <= mem[rd_ptr_reg];
            end
            assign rd_data = rd_data_reg;
        end
    endgenerate

endmodule

// File: rtl/supply_threshold_monitor.sv
// Multi-channel supply level classifier with hysteresis, debounce, latched
// breakdown and an event FIFO reporting every committed level change.
module supply_threshold_monitor
    import supply_mon_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int W         = 8,
    parameter int DEBOUNCE  = 3,
    parameter int DCNT_W    = 4,
    parameter int EVT_DEPTH = 4,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              smp_valid,
    input  logic [CH_W-1:0]   smp_ch,
    input  logic [W-1:0]      smp_code,
    input  logic [W-1:0]      cfg_vref,
    input  logic [W-1:0]      cfg_vmax,
    input  logic [W-1:0]      cfg_vbrk,
    input  logic [W-1:0]      cfg_hyst,
    input  logic [NCH-1:0]    clr_brk,
    output logic [2*NCH-1:0]  level,
    output logic              warn_any,
    output logic              err_any,
    output logic              brk_any,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic [1:0]        evt_from,
    output logic [1:0]        evt_to,
    output logic              evt_ovf
);
    localparam int EVT_W = $bits(evt_t);

    lvl_t                 raw_cls;
    logic [NCH-1:0]       is_warn, is_err, is_brk, push;
    logic [NCH*EVT_W-1:0] push_data;
    logic [EVT_W-1:0]     head_bits;
    evt_t                 head;
    logic                 fifo_empty, fifo_full, fifo_drop;

    assign raw_cls = classify(smp_code > cfg_vbrk, smp_code >= cfg_vmax, smp_code >= cfg_vref);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            lvl_t              lvl_reg, lvl_next, cand_reg, cand_next, cls;
            logic [DCNT_W-1:0] cnt_reg, cnt_next;
            logic [W-1:0]      thr;
            logic              hit, push_req;
            evt_t              evt;

            assign hit = smp_valid && (smp_ch == CH_W'(gi));

            always_comb begin
                lvl_next  = lvl_reg;
                cand_next = cand_reg;
                cnt_next  = cnt_reg;
                push_req  = 1'b0;
                // Moving down requires clearing the current level's threshold by hyst.
                thr = (lvl_reg == LVL_ERR) ? cfg_vmax : cfg_vref;
                cls = raw_cls;
                if (raw_cls < lvl_reg && !(thr > cfg_hyst && smp_code < thr - cfg_hyst))
                    cls = lvl_reg;

                if (lvl_reg == LVL_BRK) begin
                    if (clr_brk[gi] && !(hit && raw_cls == LVL_BRK)) begin
                        lvl_next  = LVL_NOM;
                        cand_next = LVL_NOM;
                        cnt_next  = '0;
                        push_req  = 1'b1;
                    end
                end else if (hit) begin
                    if (cls == LVL_BRK) begin
                        lvl_next = LVL_BRK;
                        cnt_next = '0;
                        push_req = 1'b1;
                    end else if (cls == lvl_reg) begin
                        cnt_next = '0;
                    end else if (cls == cand_reg) begin
                        if (int'(cnt_reg) + 1 == DEBOUNCE) begin
                            lvl_next = cls;
                            cnt_next = '0;
                            push_req = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else begin
                        cand_next = cls;
                        cnt_next  = DCNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            lvl_next = cls;
                            cnt_next = '0;
                            push_req = 1'b1;
                        end
                    end
                end
                evt = '{ch: CH_MAX_W'(gi), from: lvl_reg, to: lvl_next};
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lvl_reg  <= LVL_NOM;
                    cand_reg <= LVL_NOM;
                    cnt_reg  <= '0;
                end else begin
                    lvl_reg  <= lvl_next;
                    cand_reg <= cand_next;
                    cnt_reg  <= cnt_next;
                end
            end

            assign level[2*gi +: 2]              = lvl_reg;
            assign is_warn[gi]                   = (lvl_reg == LVL_WARN);
            assign is_err[gi]                    = (lvl_reg == LVL_ERR);
            assign is_brk[gi]                    = (lvl_reg == LVL_BRK);
            assign push[gi]                      = push_req;
            assign push_data[gi*EVT_W +: EVT_W]  = evt;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warn_any <= 1'b0;
            err_any  <= 1'b0;
            brk_any  <= 1'b0;
            evt_ovf  <= 1'b0;
        end else begin
            warn_any <= |is_warn;
            err_any  <= |is_err;
            brk_any  <= |is_brk;
            if (fifo_drop) evt_ovf <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (EVT_DEPTH),
        .NWR   (NCH),
        .FWFT  (1'b1)
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (evt_ready),
        .rd_data (head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .drop    (fifo_drop)
    );

    assign head      = evt_t'(head_bits);
    assign evt_valid = !fifo_empty;
    assign evt_ch    = head.ch[CH_W-1:0];
    assign evt_from  = head.from;
    assign evt_to    = head.to;

endmodule

// File: tb/tb_supply_threshold_monitor.sv
// Randomised and directed bench for supply_threshold_monitor, checked against
// a run-length behavioural model with a queue-based event FIFO.
module tb_supply_threshold_monitor;
    localparam int NCH = 4, DEB = 3, DEPTH = 4;
    localparam int VREF = 50, VMAX = 70, VBRK = 90, HYST = 5;

    logic       clk = 1'b0;
    logic       rst_n, smp_valid, evt_ready;
    logic [1:0] smp_ch;
    logic [7:0] smp_code, cfg_vref, cfg_vmax, cfg_vbrk, cfg_hyst;
    logic [3:0] clr_brk;
    logic [7:0] level, level1;
    logic       warn_any, err_any, brk_any, evt_valid, evt_ovf;
    logic [1:0] evt_ch, evt_from, evt_to;
    logic       warn_any1, err_any1, brk_any1, evt_valid1, evt_ovf1;
    logic [1:0] evt_ch1, evt_from1, evt_to1;

    always #5 clk = ~clk;

    supply_threshold_monitor #(.NCH(4), .W(8), .DEBOUNCE(3), .DCNT_W(4), .EVT_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_code(smp_code),
        .cfg_vref(cfg_vref), .cfg_vmax(cfg_vmax), .cfg_vbrk(cfg_vbrk), .cfg_hyst(cfg_hyst),
        .clr_brk(clr_brk), .level(level), .warn_any(warn_any), .err_any(err_any), .brk_any(brk_any),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch), .evt_from(evt_from),
        .evt_to(evt_to), .evt_ovf(evt_ovf));

    supply_threshold_monitor #(.NCH(4), .W(8), .DEBOUNCE(1), .DCNT_W(4), .EVT_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_code(smp_code),
        .cfg_vref(cfg_vref), .cfg_vmax(cfg_vmax), .cfg_vbrk(cfg_vbrk), .cfg_hyst(cfg_hyst),
        .clr_brk(clr_brk), .level(level1), .warn_any(warn_any1), .err_any(err_any1), .brk_any(brk_any1),
        .evt_valid(evt_valid1), .evt_ready(1'b1), .evt_ch(evt_ch1), .evt_from(evt_from1),
        .evt_to(evt_to1), .evt_ovf(evt_ovf1));

    wire [12:0] act_status = {level, warn_any, err_any, brk_any, evt_valid, evt_ovf};
    wire [5:0]  act_head   = {evt_ch, evt_from, evt_to};

    int checks = 0, failures = 0;

    // Model: committed level plus the length of the current run of identical
    // off-level classes; a run of DEB commits. Events are {ch,from,to} ints.
    int mlvl [NCH];
    int mrun_cls [NCH];
    int mrun_len [NCH];
    int mq [$];
    bit movf, m_warn, m_err, m_brk;

    function automatic int raw_class(int code);
        if (code > VBRK)       return 3;
        else if (code >= VMAX) return 2;
        else if (code >= VREF) return 1;
        return 0;
    endfunction

    function automatic int eff_class(int code, int cur);
        int c = raw_class(code);
        int thr = (cur == 2) ? VMAX : VREF;
        if (c < cur && code >= thr - HYST) c = cur;
        return c;
    endfunction

    task automatic model_step();
        bit nw = 0, ne = 0, nb = 0;
        for (int i = 0; i < NCH; i++) begin
            nw |= (mlvl[i] == 1); ne |= (mlvl[i] == 2); nb |= (mlvl[i] == 3);
        end
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin mlvl[i] = 0; mrun_cls[i] = 0; mrun_len[i] = 0; end
            mq.delete(); movf = 0; m_warn = 0; m_err = 0; m_brk = 0;
            return;
        end
        if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
        for (int i = 0; i < NCH; i++) begin
            int  from = mlvl[i];
            bit  hit = smp_valid && (int'(smp_ch) == i);
            bit  commit = 0;
            if (mlvl[i] == 3) begin
                if (clr_brk[i] && !(hit && raw_class(smp_code) == 3)) begin
                    mlvl[i] = 0; mrun_len[i] = 0; commit = 1;
                end
            end else if (hit) begin
                int c = eff_class(smp_code, mlvl[i]);
                if (c == 3) begin
                    mlvl[i] = 3; mrun_len[i] = 0; commit = 1;
                end else if (c == mlvl[i]) begin
                    mrun_len[i] = 0;
                end else begin
                    if (mrun_len[i] > 0 && mrun_cls[i] == c) mrun_len[i]++;
                    else begin mrun_cls[i] = c; mrun_len[i] = 1; end
                    if (mrun_len[i] >= DEB) begin mlvl[i] = c; mrun_len[i] = 0; commit = 1; end
                end
            end
            if (commit) begin
                if (mq.size() < DEPTH) mq.push_back(i*16 + from*4 + mlvl[i]);
                else movf = 1;
            end
        end
        m_warn = nw; m_err = ne; m_brk = nb;
    endtask

    function automatic logic [12:0] exp_status();
        logic [7:0] lv;
        for (int i = 0; i < NCH; i++) lv[2*i +: 2] = 2'(mlvl[i]);
        return {lv, m_warn, m_err, m_brk, mq.size() > 0, movf};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        smp_valid = 1'b0;
        clr_brk   = '0;
    endtask

    task automatic drive(input int ch, input int code);
        smp_valid = 1'b1; smp_ch = 2'(ch); smp_code = 8'(code);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        checks++; if (level !== 8'h00) begin failures++; $display("FAIL reset_level act=%h exp=00", level); end
        checks++; if ({warn_any, err_any, brk_any} !== 3'b000) begin failures++; $display("FAIL reset_any act=%b exp=000", {warn_any, err_any, brk_any}); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_evt_valid act=%b exp=0", evt_valid); end
        checks++; if (evt_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf act=%b exp=0", evt_ovf); end
    endtask

    task automatic test_debounce1();
        drive(0, 55); tick();
        checks++; if (level1[1:0] !== 2'd1) begin failures++; $display("FAIL deb1_warn act=%0d exp=1", level1[1:0]); end
        checks++; if (act_status !== exp_status()) begin failures++; $display("FAIL deb1_main act=%h exp=%h", act_status, exp_status()); end
    endtask

    task automatic test_ramp();
        do_reset(); evt_ready = 1'b1;
        for (int c = 0; c <= 90; c += 10) begin
            drive(0, c); tick();
            checks++; if (act_status !== exp_status()) begin failures++; $display("FAIL ramp code=%0d act=%h exp=%h", c, act_status, exp_status()); end
            if (c == 80) begin checks++; if (level[1:0] !== 2'd0) begin failures++; $display("FAIL ramp_nocommit act=%0d exp=0", level[1:0]); end end
        end
        checks++; if (level[1:0] !== 2'd2) begin failures++; $display("FAIL ramp_err act=%0d exp=2", level[1:0]); end
        do_reset();
        for (int n = 1; n <= 3; n++) begin
            drive(0, 55); tick();
            checks++; if (level[1:0] !== ((n == 3) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL warn55 n=%0d act=%0d exp=%0d", n, level[1:0], (n == 3)); end
        end
        checks++; if (!(evt_valid === 1'b1 && act_head === 6'b00_00_01)) begin failures++; $display("FAIL warn55_evt act=%b/%b exp=1/000001", evt_valid, act_head); end
    endtask

    task automatic test_brk();
        int codes [5] = '{91, -1, 0, 0, 0};
        do_reset(); evt_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (codes[n] >= 0) drive(1, codes[n]);
            tick();
            checks++; if (act_status !== exp_status()) begin failures++; $display("FAIL brk step=%0d act=%h exp=%h", n, act_status, exp_status()); end
            if (n == 0) begin
                checks++; if ({level[3:2], brk_any} !== 3'b110) begin failures++; $display("FAIL brk_latency act=%b exp=110", {level[3:2], brk_any}); end
                checks++; if (act_head !== 6'b01_00_11) begin failures++; $display("FAIL brk_evt act=%b exp=010011", act_head); end
            end
            if (n == 1) begin checks++; if (brk_any !== 1'b1) begin failures++; $display("FAIL brk_any act=%b exp=1", brk_any); end end
        end
        checks++; if (level[3:2] !== 2'd3) begin failures++; $display("FAIL brk_sticky act=%0d exp=3", level[3:2]); end
        clr_brk = 4'b0010; tick();
        checks++; if (!(level[3:2] === 2'd0 && act_head === 6'b01_11_00)) begin failures++; $display("FAIL brk_clear act=%0d/%b exp=0/011100", level[3:2], act_head); end
        // Clear and a breakdown-class sample together: the sample keeps the latch.
        drive(2, 95); tick(); tick();
        clr_brk = 4'b0100; drive(2, 100); tick();
        checks++; if (level[5:4] !== 2'd3) begin failures++; $display("FAIL clr_vs_brk act=%0d exp=3", level[5:4]); end
        checks++; if (act_status !== exp_status()) begin failures++; $display("FAIL clr_vs_brk_status act=%h exp=%h", act_status, exp_status()); end
    endtask

    task automatic test_hyst();
        int codes [9] = '{55, 55, 55, 47, 47, 47, 44, 44, 44};
        do_reset(); evt_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            drive(2, codes[n]); tick();
            checks++; if (act_status !== exp_status()) begin failures++; $display("FAIL hyst step=%0d act=%h exp=%h", n, act_status, exp_status()); end
            if (n == 5) begin checks++; if (level[5:4] !== 2'd1) begin failures++; $display("FAIL hyst_hold act=%0d exp=1", level[5:4]); end end
        end
        checks++; if (level[5:4] !== 2'd0) begin failures++; $display("FAIL hyst_down act=%0d exp=0", level[5:4]); end
    endtask

    task automatic test_interleave();
        int chs [5] = '{0, 3, 0, 3, 0};
        do_reset(); evt_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            drive(chs[n], 75); tick();
            checks++; if (act_status !== exp_status()) begin failures++; $display("FAIL ileave step=%0d act=%h exp=%h", n, act_status, exp_status()); end
        end
        checks++; if ({level[7:6], level[1:0]} !== 4'b00_10) begin failures++; $display("FAIL ileave_final act=%b exp=0010", {level[7:6], level[1:0]}); end
    endtask

    task automatic test_back_to_back();
        do_reset(); evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin drive(i, 91); tick(); end
        evt_ready = 1'b1; clr_brk = 4'b0001; tick();
        checks++; if ({evt_valid, evt_ovf} !== 2'b10) begin failures++; $display("FAIL b2b_full act=%b exp=10", {evt_valid, evt_ovf}); end
        checks++; if (act_head !== 6'b01_00_11) begin failures++; $display("FAIL b2b_head act=%b exp=010011", act_head); end
        checks++; if (act_status !== exp_status()) begin failures++; $display("FAIL b2b_status act=%h exp=%h", act_status, exp_status()); end
    endtask

    task automatic test_overflow();
        do_reset(); evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin drive(i, 91); tick(); end
        clr_brk = 4'b0001; tick();
        checks++; if (evt_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set act=%b exp=1", evt_ovf); end
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (!(evt_valid === 1'b1 && act_head === 6'(i*16 + 3))) begin failures++; $display("FAIL drain i=%0d act=%b/%b exp=1/%b", i, evt_valid, act_head, 6'(i*16 + 3)); end
            tick();
        end
        checks++; if ({evt_valid, evt_ovf} !== 2'b01) begin failures++; $display("FAIL drained act=%b exp=01", {evt_valid, evt_ovf}); end
        evt_ready = 1'b0; drive(0, 60); tick(); clr_brk = 4'b1110; tick();
        do_reset();
        checks++; if (act_status !== 13'h0) begin failures++; $display("FAIL midreset act=%h exp=0000", act_status); end
    endtask

    task automatic test_random();
        int near [3] = '{VREF, VMAX, VBRK};
        do_reset();
        for (int n = 0; n < 600; n++) begin
            smp_valid = ($urandom_range(0, 3) != 0);
            smp_ch    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) smp_code = 8'($urandom_range(0, 255));
            else smp_code = 8'(near[$urandom_range(0, 2)] + int'($urandom_range(0, 12)) - 8);
            clr_brk   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            evt_ready = ($urandom_range(0, 2) != 0);
            tick();
            checks++; if (act_status !== exp_status()) begin failures++; $display("FAIL rand n=%0d status act=%h exp=%h", n, act_status, exp_status()); end
            if (mq.size() > 0) begin
                checks++; if (act_head !== 6'(mq[0])) begin failures++; $display("FAIL rand n=%0d head act=%b exp=%b", n, act_head, 6'(mq[0])); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; smp_valid = 1'b0; smp_ch = '0; smp_code = '0; clr_brk = '0; evt_ready = 1'b1;
        cfg_vref = 8'(VREF); cfg_vmax = 8'(VMAX); cfg_vbrk = 8'(VBRK); cfg_hyst = 8'(HYST);
        test_reset();
        test_debounce1();
        test_ramp();
        test_brk();
        test_hyst();
        test_interleave();
        test_back_to_back();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
